// File: rtl/gb_ucode_sequencer.sv
// -----------------------------------------------------------------------------
// gb_ucode_sequencer
// Microcode sequencer for the CPU control unit. Tracks the current opcode,
// the CB-prefix table selection and the micro-step, addresses the microcode
// ROM and forwards the selected 70-bit control word to the field mapper.
//
// Ports:
//   clk, rst         single rising-edge clock, synchronous active-high reset
//   inst_byte/valid  opcode byte handshake, only sampled while in FETCH
//   cond_met         evaluated branch condition for COND micro-ops
//   stall            global hold (memory wait), lower priority than rst
//   ucode_addr       {cb_mode, opcode, step} straight from the registers
//   ucode_data       ROM word for ucode_addr, same cycle
//   control_signals  NOP_WORD in reset, FETCH_WORD in FETCH, ROM word in EXEC
//   in_fetch         high while waiting for an opcode byte
//   cb_mode          CB-prefix table selected for the current/next opcode
//   ucode_overflow   sticky: the micro-program tried to step past the last step
//
// Optional build macro GB_SEQ_PERF_EN adds the free-running performance
// counters instr_retired[31:0] and stall_cycles[31:0].
// -----------------------------------------------------------------------------
module gb_ucode_sequencer #(
    parameter int          STEP_W     = 3,
    parameter logic [69:0] FETCH_WORD = 70'h0,
    parameter logic [69:0] NOP_WORD   = 70'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        inst_byte,
    input  logic              inst_valid,
    input  logic              cond_met,
    input  logic              stall,
    output logic [STEP_W+8:0] ucode_addr,
    input  logic [69:0]       ucode_data,
    output logic [69:0]       control_signals,
    output logic              in_fetch,
    output logic              cb_mode,
    output logic              ucode_overflow
`ifdef GB_SEQ_PERF_EN
    ,
    output logic [31:0]       instr_retired,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;

    localparam logic [1:0]        ADV_NEXT  = 2'b00;
    localparam logic [1:0]        ADV_END   = 2'b01;
    localparam logic [1:0]        ADV_COND  = 2'b10;
    localparam logic [STEP_W-1:0] LAST_STEP = '1;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        opcode_q, opcode_d;
    logic              cb_mode_q, cb_mode_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        adv_sel;
    logic              advance;
    logic              finish;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            step_q    <= '0;
            opcode_q  <= 8'h00;
            cb_mode_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            opcode_q  <= opcode_d;
            cb_mode_q <= cb_mode_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic. WAIT (2'b11) falls through both advance and finish,
    // so the step holds and the same ROM word is re-issued next cycle.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        opcode_d  = opcode_q;
        cb_mode_d = cb_mode_q;
        ovf_d     = ovf_q;
        adv_sel   = ucode_data[34:33];
        advance   = (adv_sel == ADV_NEXT) || ((adv_sel == ADV_COND) && cond_met);
        finish    = (adv_sel == ADV_END)  || ((adv_sel == ADV_COND) && !cond_met);

        if (state_q == S_FETCH) begin
            if (inst_valid && !stall) begin
                opcode_d = inst_byte;
                step_d   = '0;
                state_d  = S_EXEC;
            end
        end else if (!stall) begin
            if (advance) begin
                if (step_q == LAST_STEP) begin
                    // Runaway micro-program: flag it and abandon the
                    // instruction instead of wrapping into its own step 0.
                    ovf_d     = 1'b1;
                    step_d    = '0;
                    state_d   = S_FETCH;
                    cb_mode_d = 1'b0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end else if (finish) begin
                step_d    = '0;
                state_d   = S_FETCH;
                cb_mode_d = ucode_data[48];
            end
        end
    end

    // Output logic
    always_comb begin
        ucode_addr     = {cb_mode_q, opcode_q, step_q};
        in_fetch       = (state_q == S_FETCH);
        cb_mode        = cb_mode_q;
        ucode_overflow = ovf_q;
        if (rst) begin
            control_signals = NOP_WORD;
        end else if (state_q == S_FETCH) begin
            control_signals = FETCH_WORD;
        end else begin
            control_signals = ucode_data;
        end
    end

`ifdef GB_SEQ_PERF_EN
    logic [31:0] instr_retired_q, instr_retired_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Every EXEC->FETCH transition is an instruction end (END, COND not
    // taken, or overflow), so retirement is derived from the transition.
    always_comb begin
        instr_retired_d = instr_retired_q;
        stall_cycles_d  = stall_cycles_q;
        if ((state_q == S_EXEC) && (state_d == S_FETCH)) begin
            instr_retired_d = instr_retired_q + 32'd1;
        end
        if ((state_q == S_EXEC) && stall) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_retired_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            instr_retired_q <= instr_retired_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign instr_retired = instr_retired_q;
    assign stall_cycles  = stall_cycles_q;
`endif

endmodule

// File: tb/tb_gb_ucode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gb_ucode_sequencer
// Self-checking bench for gb_ucode_sequencer: a behavioural ROM drives
// ucode_data, a reference model predicts the outputs of each cycle, the
// prediction is queued when the stimulus is driven and popped/compared at
// the falling edge. Directed spot checks reinforce the key scenarios.
// -----------------------------------------------------------------------------
module tb_gb_ucode_sequencer;

    localparam logic [69:0] FW = 70'h0F0F_0000_0000_F00D;
    localparam logic [69:0] NW = 70'h1234_0000_0000_0BAD;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inst_byte;
    logic        inst_valid;
    logic        cond_met;
    logic        stall;
    logic [11:0] ucode_addr;
    logic [69:0] ucode_data;
    logic [69:0] control_signals;
    logic        in_fetch;
    logic        cb_mode;
    logic        ucode_overflow;
`ifdef GB_SEQ_PERF_EN
    logic [31:0] instr_retired;
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    gb_ucode_sequencer #(
        .STEP_W    (3),
        .FETCH_WORD(FW),
        .NOP_WORD  (NW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_byte      (inst_byte),
        .inst_valid     (inst_valid),
        .cond_met       (cond_met),
        .stall          (stall),
        .ucode_addr     (ucode_addr),
        .ucode_data     (ucode_data),
        .control_signals(control_signals),
        .in_fetch       (in_fetch),
        .cb_mode        (cb_mode),
        .ucode_overflow (ucode_overflow)
`ifdef GB_SEQ_PERF_EN
        ,
        .instr_retired  (instr_retired),
        .stall_cycles   (stall_cycles)
`endif
    );

    // Behavioural microcode ROM
    logic [69:0] rom [0:4095];
    assign ucode_data = rom[ucode_addr];

    function automatic logic [69:0] mk(input logic [1:0] adv, input logic tcb, input logic [11:0] tag);
        logic [69:0] w;
        w       = '0;
        w[69]   = 1'b1;
        w[48]   = tcb;
        w[34:33] = adv;
        w[11:0] = tag;
        return w;
    endfunction

    function automatic logic [11:0] ad(input logic cb, input logic [7:0] op, input int st);
        logic [2:0] s;
        s = st[2:0];
        return {cb, op, s};
    endfunction

    // Reference model state
    logic        m_fetch;
    logic [2:0]  m_step;
    logic [7:0]  m_op;
    logic        m_cb;
    logic        m_ovf;
    int unsigned m_ret;
    int unsigned m_stl;

    typedef struct {
        logic [11:0] addr;
        logic [69:0] cs;
        logic        fetch;
        logic        cb;
        logic        ovf;
        int unsigned ret;
        int unsigned stl;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_no = 0;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = 1'b1;
        m_step  = 3'd0;
        m_op    = 8'h00;
        m_cb    = 1'b0;
        m_ovf   = 1'b0;
        m_ret   = 0;
        m_stl   = 0;
    endtask

    task automatic model_edge(input logic r, v, input logic [7:0] b, input logic c, s);
        logic [69:0] w;
        logic [1:0]  adv;
        if (r) begin
            model_reset();
        end else if (m_fetch) begin
            if (v && !s) begin
                m_op    = b;
                m_step  = 3'd0;
                m_fetch = 1'b0;
            end
        end else if (s) begin
            m_stl++;
        end else begin
            w   = rom[{m_cb, m_op, m_step}];
            adv = w[34:33];
            if (adv == 2'b00 || (adv == 2'b10 && c)) begin
                if (m_step == 3'd7) begin
                    m_ovf   = 1'b1;
                    m_fetch = 1'b1;
                    m_step  = 3'd0;
                    m_cb    = 1'b0;
                    m_ret++;
                end else begin
                    m_step = m_step + 3'd1;
                end
            end else if (adv == 2'b01 || adv == 2'b10) begin
                m_fetch = 1'b1;
                m_step  = 3'd0;
                m_cb    = w[48];
                m_ret++;
            end
        end
    endtask

    // One clock: drive inputs, queue the prediction, compare at negedge,
    // advance the model, then move past the next rising edge.
    task automatic cyc(input logic r, v, input logic [7:0] b, input logic c, s);
        exp_t e;
        rst = r; inst_valid = v; inst_byte = b; cond_met = c; stall = s;
        e.addr  = {m_cb, m_op, m_step};
        e.cs    = r ? NW : (m_fetch ? FW : rom[{m_cb, m_op, m_step}]);
        e.fetch = m_fetch;
        e.cb    = m_cb;
        e.ovf   = m_ovf;
        e.ret   = m_ret;
        e.stl   = m_stl;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("ucode_addr", 70'(ucode_addr), 70'(e.addr));
        chk("control_signals", control_signals, e.cs);
        chk("in_fetch", 70'(in_fetch), 70'(e.fetch));
        chk("cb_mode", 70'(cb_mode), 70'(e.cb));
        chk("ucode_overflow", 70'(ucode_overflow), 70'(e.ovf));
`ifdef GB_SEQ_PERF_EN
        chk("instr_retired", 70'(instr_retired), 70'(e.ret));
        chk("stall_cycles", 70'(stall_cycles), 70'(e.stl));
`endif
        $display("cycle %0d rst=%0b v=%0b byte=%h cond=%0b stall=%0b addr=%h fetch=%0b cb=%0b ovf=%0b",
                 cyc_no, r, v, b, c, s, ucode_addr, in_fetch, cb_mode, ucode_overflow);
        cyc_no++;
        model_edge(r, v, b, c, s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] ops [7];
`ifdef GB_SEQ_PERF_EN
        int unsigned stl0;
`endif
        ops = '{8'h3E, 8'hCB, 8'h11, 8'h20, 8'h77, 8'h61, 8'h00};

        // Default ROM: every word ends the instruction
        for (int a = 0; a < 4096; a++) rom[a] = mk(2'b01, 1'b0, 12'(a));
        rom[ad(0, 8'h3E, 0)] = mk(2'b00, 1'b1, 12'h301);   // NEXT, toggle ignored
        rom[ad(0, 8'h3E, 1)] = mk(2'b00, 1'b0, 12'h302);
        rom[ad(0, 8'h3E, 2)] = mk(2'b01, 1'b0, 12'h303);
        rom[ad(0, 8'hCB, 0)] = mk(2'b01, 1'b1, 12'hCB0);   // CB prefix
        rom[ad(1, 8'h11, 0)] = mk(2'b00, 1'b0, 12'h110);
        rom[ad(1, 8'h11, 1)] = mk(2'b01, 1'b0, 12'h111);
        rom[ad(0, 8'h20, 0)] = mk(2'b00, 1'b0, 12'h200);
        rom[ad(0, 8'h20, 1)] = mk(2'b10, 1'b0, 12'h201);   // COND
        rom[ad(0, 8'h20, 2)] = mk(2'b01, 1'b0, 12'h202);
        rom[ad(0, 8'h50, 0)] = mk(2'b11, 1'b0, 12'h500);   // WAIT
        for (int s = 0; s < 8; s++) begin
            rom[ad(0, 8'h77, s)] = mk(2'b00, 1'b0, 12'(12'h770 + s));
            rom[ad(1, 8'h61, s)] = mk(2'b00, 1'b0, 12'(12'h610 + s));
        end
        rom[ad(1, 8'h61, 7)] = mk(2'b10, 1'b1, 12'h617);   // COND at last step

        model_reset();
        rst = 1'b1; inst_valid = 1'b0; inst_byte = 8'h00; cond_met = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);                  // reset state, NOP word
        chk("rst_in_fetch", 70'(in_fetch), 70'(1'b1));

        // First fetch and 3-step op
        cyc(1'b0, 1'b1, 8'h3E, 1'b0, 1'b0);
        chk("first_addr", 70'(ucode_addr), 70'({1'b0, 8'h3E, 3'd0}));
        chk("first_exec", 70'(in_fetch), 70'(1'b0));
        idle(3);
        chk("op3_done", 70'(in_fetch), 70'(1'b1));
        chk("op3_cb", 70'(cb_mode), 70'(1'b0));

        // Stalled fetch is not accepted
        cyc(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
        chk("fetch_stall", 70'(in_fetch), 70'(1'b1));

        // CB prefix then CB-table opcode
        cyc(1'b0, 1'b1, 8'hCB, 1'b0, 1'b0);
        idle(1);
        chk("cb_set", 70'(cb_mode), 70'(1'b1));
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("cb_addr", 70'(ucode_addr), 70'({1'b1, 8'h11, 3'd0}));
        idle(2);
        chk("cb_clear", 70'(cb_mode), 70'(1'b0));

        // COND not taken, then taken
        cyc(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("cond_nt", 70'(in_fetch), 70'(1'b1));
        cyc(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("cond_t", 70'(ucode_addr), 70'({1'b0, 8'h20, 3'd2}));
        idle(1);

        // Stall for 3 cycles at step 1, inst_valid ignored in EXEC
        cyc(1'b0, 1'b1, 8'h3E, 1'b0, 1'b0);
        idle(1);
`ifdef GB_SEQ_PERF_EN
        stl0 = stall_cycles;
`endif
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        chk("stall_step", 70'(ucode_addr), 70'({1'b0, 8'h3E, 3'd1}));
`ifdef GB_SEQ_PERF_EN
        chk("stall_cnt", 70'(stall_cycles - stl0), 70'(3));
`endif
        idle(2);

        // WAIT loops until the ROM word changes
        cyc(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
        idle(3);
        chk("wait_hold", 70'(in_fetch), 70'(1'b0));
        rom[ad(0, 8'h50, 0)] = mk(2'b01, 1'b0, 12'h501);
        idle(1);

        // Overflow via NEXT at the last step
        cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        idle(8);
        chk("ovf_set", 70'(ucode_overflow), 70'(1'b1));
        chk("ovf_fetch", 70'(in_fetch), 70'(1'b1));

        // Overflow via taken COND in CB table: toggle ignored, cb cleared
        cyc(1'b0, 1'b1, 8'hCB, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_cond_cb", 70'(cb_mode), 70'(1'b0));

        // Reset mid-instruction clears sticky overflow and aborts
        cyc(1'b0, 1'b1, 8'h3E, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_mid_addr", 70'(ucode_addr), 70'(12'h000));
        chk("rst_mid_fetch", 70'(in_fetch), 70'(1'b1));
        chk("rst_mid_ovf", 70'(ucode_overflow), 70'(1'b0));

        // Randomised mix
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
